// File: rtl/imem_responder.sv
// Instruction-memory responder: word array with a preload port, and a fixed-latency
// valid/ready fetch response. Define IMEM_TRACE_EN to print each completed response.
//
// state | meaning
// IDLE  | ready for a fetch request; capture inst/err on req_valid
// WAIT  | latency counter running down toward the response
// RESP  | rsp_valid high, captured outputs held until rsp_ready
module imem_responder #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(LAT - 1);
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          capture;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          addr_err;
  logic [31:0]   rsp_inst_q;
  logic          rsp_err_q;

  // Offset is modular, so addresses below BASE wrap to huge offsets and fail the range test.
  assign off      = req_addr - BASE;
  assign idx      = off[AW+1:2];
  assign addr_err = (req_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_inst_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        rsp_inst_q <= addr_err ? 32'h0 : mem[idx];
        rsp_err_q  <= addr_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;

`ifdef IMEM_TRACE_EN
  logic [31:0] addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else if (capture) addr_q <= req_addr;
  end

  always @(posedge clk) begin
    if (rst && rsp_valid && rsp_ready)
      $display("ITRACE addr=%08h inst=%08h err=%0d", addr_q, rsp_inst_q, rsp_err_q);
  end
`endif

endmodule
